// File: rtl/light_dance_sequencer_pkg.sv
// Shared types and defaults for the light-dance sequencer and its datapath link.
package light_dance_pkg;

    localparam int NUM_PAT_DEF = 4;
    localparam int DIV_W_DEF   = 16;
    localparam int SPP_W_DEF   = 4;
    localparam int PAT_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_ADVANCE,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/light_dance_sequencer_if.sv
// Link between the sequencer (master) and the 8-bit load/shift datapath (slave).
interface light_dance_sequencer_if;
    import light_dance_pkg::*;

    logic             ld_load;
    logic [PAT_W-1:0] ld_pdata;
    logic             ld_din;
    logic             ld_shift_en;
    logic [PAT_W-1:0] ld_qdata;

    modport master (
        output ld_load,
        output ld_pdata,
        output ld_din,
        output ld_shift_en,
        input  ld_qdata
    );

    modport slave (
        input  ld_load,
        input  ld_pdata,
        input  ld_din,
        input  ld_shift_en,
        output ld_qdata
    );
endinterface

// File: rtl/light_dance_sequencer_step_prescaler.sv
// Step pacing counter: counts 0..period and emits a one-cycle tick on the
// terminal count. Held at zero while clr is high.
module step_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Next count and tick; the counter clears on its own tick so it never passes period.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == period) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/light_dance_sequencer.sv
// Sequencer for the light-dance shift register: loads table patterns, issues
// paced shift strobes, walks the table once or in a loop.
module light_dance_sequencer
    import light_dance_pkg::*;
#(
    parameter int NUM_PAT = NUM_PAT_DEF,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int SPP_W   = SPP_W_DEF,
    localparam int IDX_W  = $clog2(NUM_PAT)
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [PAT_W-1:0]   cfg_data,
    input  logic [DIV_W-1:0]   step_div,
    input  logic [SPP_W-1:0]   shifts_per_pat,
    input  logic               loop_en,
    input  logic               din_mode,
    input  logic               din_val,
    input  logic               start,
    input  logic               stop,
    light_dance_sequencer_if.master ld,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   cur_idx
);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [SPP_W-1:0]              scnt_q, scnt_d;
    logic [PAT_W-1:0]              pdata_q, pdata_d;
    logic [DIV_W-1:0]              div_q, div_d;
    logic [SPP_W-1:0]              spp_q, spp_d;
    logic                          loop_q, loop_d;
    logic                          mode_q, mode_d;
    logic [NUM_PAT-1:0][PAT_W-1:0] tbl_q;
    logic                          step_tick;
    logic                          unused_qdata;

    // Only bit 7 of the datapath is fed back (rotate mode).
    assign unused_qdata = ^ld.ld_qdata[PAT_W-2:0];

    step_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk    (clk),
        .arst   (arst),
        .clr    (state_q != ST_DWELL),
        .period (div_q),
        .tick   (step_tick)
    );

    // Pattern table: host writes land at the edge, so a same-cycle LOAD sees the old value.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst)       tbl_q <= '0;
        else if (cfg_we) tbl_q[cfg_addr] <= cfg_data;
    end

    // State, index, shift count, held pattern and run snapshot registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            scnt_q  <= '0;
            pdata_q <= '0;
            div_q   <= '0;
            spp_q   <= '0;
            loop_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            scnt_q  <= scnt_d;
            pdata_q <= pdata_d;
            div_q   <= div_d;
            spp_q   <= spp_d;
            loop_q  <= loop_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and strobe decode; stop overrides everything outside IDLE.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        scnt_d         = scnt_q;
        pdata_d        = pdata_q;
        div_d          = div_q;
        spp_d          = spp_q;
        loop_d         = loop_q;
        mode_d         = mode_q;
        ld.ld_load     = 1'b0;
        ld.ld_shift_en = 1'b0;
        ld.ld_pdata    = pdata_q;
        done           = 1'b0;

        if (stop && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        div_d   = step_div;
                        spp_d   = shifts_per_pat;
                        loop_d  = loop_en;
                        mode_d  = din_mode;
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ld.ld_load  = 1'b1;
                    ld.ld_pdata = tbl_q[idx_q];
                    pdata_d     = tbl_q[idx_q];
                    scnt_d      = '0;
                    state_d     = ST_DWELL;
                end
                ST_DWELL: begin
                    // A zero shift count still dwells one full step period.
                    if (step_tick) begin
                        if (spp_q == '0) begin
                            state_d = ST_ADVANCE;
                        end else begin
                            ld.ld_shift_en = 1'b1;
                            scnt_d         = scnt_q + 1'b1;
                            if (scnt_d == spp_q) state_d = ST_ADVANCE;
                        end
                    end
                end
                ST_ADVANCE: begin
                    if (idx_q == IDX_W'(NUM_PAT - 1)) begin
                        if (loop_q) begin
                            idx_d   = '0;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
                ST_FINISH: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ld.ld_din = mode_q ? ld.ld_qdata[PAT_W-1] : din_val;
    assign busy      = (state_q != ST_IDLE);
    assign cur_idx   = idx_q;

endmodule
